mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the 64 kB asynchronous memory between two requesters: requester 0 is the 6502 core, requester 1 is a DMA/loader port.
- Sequences each access through a programmable number of wait cycles while the memory is enabled, then returns a one-cycle response to the requester that owns the access.
- Sits directly between the requesters and the ram model; it is the only driver of the memory's enable, address and write data.

Parameters:
- ADDR_WIDTH, 16, memory address width (64 kB space).
- DATA_WIDTH, 8, memory data width.
- WAIT_CYCLES, 2, cycles mem_enable is held per access; legal range 1..15. It must cover the memory's access delay.

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester access request; held until accepted.
- req_ready  out  2  per-requester accept. The access transfers on the cycle where req_valid[i] & req_ready[i].
- req_we  in  2  per-requester write (1) / read (0).
- req_addr  in  2*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  per-requester write data, packed the same way.
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid when any rsp_valid bit is set.
- busy  out  1  high whenever the state is not IDLE.
- mem_enable  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn, sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE; owner = 0; last_grant = 1, so requester 0 wins the first tie; wait counter = 0.
  - rsp_valid = 0; rsp_rdata = 0; busy = 0.
  - mem_enable = 0; mem_we = 0; mem_address = 0; mem_wr_data = 0.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - req_ready is combinational: the winner's bit is 1 when its req_valid is 1; the loser's bit is 0.
  - Winner selection:
    - Only one requester valid: that requester wins.
    - Both valid: the requester != last_grant wins (round-robin).
  - On accept:
    - Register the winner's we, address and wdata onto the mem_* outputs.
    - Set owner and last_grant to the winner.
    - Load the counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - mem_enable = 1; mem_address, mem_we and mem_wr_data are held stable; req_ready = 0.
  - The counter decrements each cycle.
  - On the cycle the counter is 0:
    - Reads: capture mem_rd_data into rsp_rdata.
    - Writes: load 0 into rsp_rdata.
    - Go to DONE.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- DONE:
  - mem_enable = 0; mem_we = 0; rsp_valid[owner] = 1 for exactly one cycle; req_ready = 0.
  - Unconditionally go to IDLE.
- Timing: accept at cycle t, mem_enable high t+1..t+WAIT_CYCLES, rsp_valid at t+WAIT_CYCLES+1. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- Held requests: a request arriving while busy, or losing arbitration, sees req_ready = 0 and must hold valid and payload. It is considered at the next IDLE cycle. No request is dropped.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Mid-access reset: resetn low at any state aborts the access. On that edge all outputs return to reset values, no rsp_valid is issued, and the requester must re-issue.
- Widths: addresses are never modified (no wrap or increment). The counter is 4 bits.

Decomposition:
- Package mem_arbiter_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - requester index constants REQ_CPU = 0, REQ_DMA = 1;
  - NUM_REQ = 2;
  - a counter width constant.
- Sub-module mem_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req_valid and last_grant.
  - Outputs: grant one-hot and grant index.
  - Instantiated once.

Test Plan:
- Single read, WAIT_CYCLES=2: req0 reads 0x1234, memory drives 0xA5.
  - req_ready[0]=1 at t.
  - mem_enable=1, mem_address=0x1234, mem_we=0 at t+1..t+2.
  - rsp_valid=2'b01 with rsp_rdata=0xA5 at t+3; busy=0 at t+4.
- Single write: req1 writes 0x00FF <= 0x3C.
  - mem_we=1, mem_wr_data=0x3C for 2 cycles.
  - rsp_valid=2'b10 with rsp_rdata=0x00.
  - A follow-up read of 0x00FF returns 0x3C.
- Tie after reset: both requesters continuously valid for 4 accesses.
  - Grant order 0,1,0,1.
  - Each rsp_valid bit matches its requester.
- Request while busy: req1 asserts one cycle after req0 is accepted.
  - req_ready[1]=0 through DONE.
  - req1 is accepted on the first IDLE cycle, t+4 for WAIT_CYCLES=2.
- Reset mid-access: drop resetn during the second ACCESS cycle.
  - All outputs return to reset values at the next edge.
  - No rsp_valid is issued; the next tie goes to requester 0.
- WAIT_CYCLES=1 build: back-to-back reads from req0.
  - mem_enable high 1 cycle.
  - rsp_valid every 3 cycles with correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state type and constants for the two-requester memory arbiter
package mem_arbiter_pkg;
    localparam int NUM_REQ   = 2;
    localparam int REQ_CPU   = 0;
    localparam int REQ_DMA   = 1;
    localparam int CNT_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side bus of the memory arbiter
//   req_valid/req_ready/req_we : per-requester handshake and direction
//   req_addr/req_wdata         : per-requester payload, requester i at [i*W +: W]
//   rsp_valid/rsp_rdata        : one-cycle completion pulse and read data
//   master modport = requesters, slave modport = arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    import mem_arbiter_pkg::*;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: combinational 2-way round-robin picker
//   req_valid  : pending requests
//   last_grant : requester served most recently
//   grant      : one-hot winner (zero when nothing is pending)
//   grant_idx  : winner index
module mem_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);
    // requester 1 wins when alone, or on a tie when requester 0 was served last
    assign grant_idx = req_valid[1] & (~req_valid[0] | ~last_grant);
    assign grant     = req_valid & (grant_idx ? 2'b10 : 2'b01);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one asynchronous memory between the CPU and a DMA requester
//   clk, resetn         : clock and synchronous active-low reset
//   bus                 : requester handshake, payload and response (slave side)
//   busy                : high while an access is in flight
//   mem_enable, mem_we  : memory strobes, enable held WAIT_CYCLES per access
//   mem_address, mem_wr_data, mem_rd_data : memory address and data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    mem_arbiter_if.slave          bus,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   owner;
    logic                   last_grant;
    logic                   grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    mem_rr_pick u_pick (
        .req_valid (bus.req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign busy          = state != IDLE;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            owner       <= 1'(REQ_CPU);
            last_grant  <= 1'(REQ_DMA);
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            mem_enable  <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wr_data <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    state       <= ACCESS;
                    owner       <= grant_idx;
                    last_grant  <= grant_idx;
                    cnt         <= CNT_WIDTH'(WAIT_CYCLES - 1);
                    mem_enable  <= 1'b1;
                    mem_we      <= bus.req_we[grant_idx];
                    mem_address <= grant_idx ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                             : bus.req_addr[ADDR_WIDTH-1:0];
                    mem_wr_data <= grant_idx ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : bus.req_wdata[DATA_WIDTH-1:0];
                end
                ACCESS: if (cnt == '0) begin
                    // last enabled cycle: memory data has settled, so sample it here
                    state      <= DONE;
                    rsp_rdata  <= mem_we ? '0 : mem_rd_data;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    mem_enable <= 1'b0;
                    mem_we     <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a transaction-timing model
module tb_mem_arbiter;
    localparam int W0 = 2;
    localparam int W1 = 1;

    typedef struct packed {
        logic [1:0]  ready;
        logic [1:0]  rsp;
        logic [7:0]  rdata;
        logic        busy;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } obs_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  v    [2];
    logic [1:0]  we   [2];
    logic [31:0] addr [2];
    logic [15:0] wd   [2];
    obs_t        act  [2];

    logic [7:0]  ram0 [65536];
    logic [7:0]  ram1 [65536];
    logic [7:0]  rd0, rd1, d0, d1;
    logic [15:0] a0, a1;
    logic        busy0, en0, we0, busy1, en1, we1;

    mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b0 ();
    mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b1 ();

    assign b0.req_valid = v[0];
    assign b0.req_we    = we[0];
    assign b0.req_addr  = addr[0];
    assign b0.req_wdata = wd[0];
    assign b1.req_valid = v[1];
    assign b1.req_we    = we[1];
    assign b1.req_addr  = addr[1];
    assign b1.req_wdata = wd[1];

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(b0), .busy(busy0), .mem_enable(en0), .mem_we(we0),
        .mem_address(a0), .mem_wr_data(d0), .mem_rd_data(rd0)
    );
    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1), .busy(busy1), .mem_enable(en1), .mem_we(we1),
        .mem_address(a1), .mem_wr_data(d1), .mem_rd_data(rd1)
    );

    assign act[0] = {b0.req_ready, b0.rsp_valid, b0.rsp_rdata, busy0, en0, we0, a0, d0};
    assign act[1] = {b1.req_ready, b1.rsp_valid, b1.rsp_rdata, busy1, en1, we1, a1, d1};

    // asynchronous memories: combinational read, written while enabled for a write
    assign rd0 = ram0[a0];
    assign rd1 = ram1[a1];

    function automatic logic [7:0] init_val(int a);
        logic [15:0] x;
        x = a[15:0];
        return x[7:0] ^ x[15:8];
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram0[a] = init_val(a);
            ram1[a] = init_val(a);
        end
        ram0[16'h1234] = 8'hA5;
        forever begin
            @(posedge clk);
            if (en0 && we0) ram0[a0] = d0;
            if (en1 && we1) ram1[a1] = d1;
        end
    end

    // reference model: each instance remembers only the cycle of its last accept
    // and that transaction; every output follows from the elapsed time since then
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 0;
    int          wc  [2] = '{W0, W1};
    int          acc [2] = '{-1000, -1000};
    int          own [2];
    int          lg  [2];
    logic        we_m   [2];
    logic [15:0] addr_m [2];
    logic [7:0]  wd_m   [2];
    logic [7:0]  rd_m   [2];
    logic [7:0]  shadow [int];
    int          mw;

    function automatic int pick(logic [1:0] vv, int last);
        if (vv == 2'b11) return 1 - last;
        return vv[1] ? 1 : 0;
    endfunction

    function automatic logic [1:0] rdy(logic [1:0] vv, int last);
        if (vv == 2'b00) return 2'b00;
        return pick(vv, last) == 1 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] mem_val(int j, int a);
        int key = j * 65536 + a;
        return shadow.exists(key) ? shadow[key] : init_val(a);
    endfunction

    initial begin
        shadow[16'h1234] = 8'hA5;
        forever begin
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (!resetn) begin
                    started   = 1;
                    acc[j]    = -1000;
                    own[j]    = 0;
                    lg[j]     = 1;
                    we_m[j]   = 1'b0;
                    addr_m[j] = '0;
                    wd_m[j]   = '0;
                    rd_m[j]   = '0;
                end else if (cyc - acc[j] >= wc[j] + 2 && v[j] != 2'b00) begin
                    mw        = pick(v[j], lg[j]);
                    acc[j]    = cyc;
                    own[j]    = mw;
                    lg[j]     = mw;
                    we_m[j]   = we[j][mw];
                    addr_m[j] = addr[j][mw*16 +: 16];
                    wd_m[j]   = wd[j][mw*8 +: 8];
                    if (we_m[j]) begin
                        shadow[j * 65536 + int'(addr_m[j])] = wd_m[j];
                        rd_m[j] = '0;
                    end else begin
                        rd_m[j] = mem_val(j, int'(addr_m[j]));
                    end
                end
            end
            cyc++;
        end
    end

    task automatic chk(string n, int j, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", n, j, cyc, a, e);
        end
    endtask

    int p;
    bit idl, en_e, done;

    initial forever begin
        @(negedge clk);
        #2;
        if (started) begin
            for (int j = 0; j < 2; j++) begin
                p    = cyc - acc[j];
                idl  = p >= wc[j] + 2;
                en_e = p >= 1 && p <= wc[j];
                done = p == wc[j] + 1;
                chk("req_ready", j, 32'(act[j].ready), 32'(idl ? rdy(v[j], lg[j]) : 2'b00));
                chk("busy", j, 32'(act[j].busy), 32'(!idl));
                chk("mem_enable", j, 32'(act[j].en), 32'(en_e));
                chk("mem_we", j, 32'(act[j].we), 32'(en_e & we_m[j]));
                chk("mem_address", j, 32'(act[j].addr), 32'(addr_m[j]));
                chk("mem_wr_data", j, 32'(act[j].wdata), 32'(wd_m[j]));
                chk("rsp_valid", j, 32'(act[j].rsp), 32'(done ? (own[j] == 1 ? 2'b10 : 2'b01) : 2'b00));
                if (done || acc[j] < 0) chk("rsp_rdata", j, 32'(act[j].rdata), 32'(rd_m[j]));
            end
        end
    end

    task automatic setr(int j, int i, logic val, logic w, logic [15:0] a, logic [7:0] d);
        v[j][i]          = val;
        we[j][i]         = w;
        addr[j][i*16 +: 16] = a;
        wd[j][i*8 +: 8]     = d;
    endtask

    bit         grants [$];
    logic [1:0] accd [2];
    int         pulses, en_cnt, first;

    initial begin
        for (int j = 0; j < 2; j++) begin
            v[j] = '0; we[j] = '0; addr[j] = '0; wd[j] = '0; accd[j] = '0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #3;
        chk("rst_busy", 0, 32'(act[0].busy), 32'd0);
        chk("rst_enable", 0, 32'(act[0].en), 32'd0);
        chk("rst_we", 0, 32'(act[0].we), 32'd0);
        chk("rst_rsp", 0, 32'(act[0].rsp), 32'd0);
        chk("rst_rdata", 0, 32'(act[0].rdata), 32'd0);
        chk("rst_addr", 0, 32'(act[0].addr), 32'd0);
        chk("rst_wdata", 0, 32'(act[0].wdata), 32'd0);

        // single read by the CPU
        @(negedge clk); setr(0, 0, 1, 0, 16'h1234, 8'h00); #3;
        chk("rd_ready", 0, 32'(act[0].ready), 32'h1);
        @(negedge clk); setr(0, 0, 0, 0, 16'h0000, 8'h00); #3;
        chk("rd_en1", 0, 32'(act[0].en), 32'd1);
        chk("rd_addr", 0, 32'(act[0].addr), 32'h1234);
        chk("rd_we", 0, 32'(act[0].we), 32'd0);
        @(negedge clk); #3;
        chk("rd_en2", 0, 32'(act[0].en), 32'd1);
        @(negedge clk); #3;
        chk("rd_rsp", 0, 32'(act[0].rsp), 32'h1);
        chk("rd_data", 0, 32'(act[0].rdata), 32'hA5);
        @(negedge clk); #3;
        chk("rd_idle", 0, 32'(act[0].busy), 32'd0);

        // single write by the DMA port, then read-back by the CPU
        @(negedge clk); setr(0, 1, 1, 1, 16'h00FF, 8'h3C); #3;
        chk("wr_ready", 0, 32'(act[0].ready), 32'h2);
        @(negedge clk); setr(0, 1, 0, 0, 16'h0000, 8'h00); #3;
        chk("wr_we1", 0, 32'(act[0].we), 32'd1);
        chk("wr_data", 0, 32'(act[0].wdata), 32'h3C);
        @(negedge clk); #3;
        chk("wr_we2", 0, 32'(act[0].we), 32'd1);
        @(negedge clk); #3;
        chk("wr_rsp", 0, 32'(act[0].rsp), 32'h2);
        chk("wr_rdata", 0, 32'(act[0].rdata), 32'h0);
        @(negedge clk);
        @(negedge clk); setr(0, 0, 1, 0, 16'h00FF, 8'h00);
        @(negedge clk); setr(0, 0, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        @(negedge clk); #3;
        chk("readback", 0, 32'(act[0].rdata), 32'h3C);
        chk("readback_rsp", 0, 32'(act[0].rsp), 32'h1);

        // DMA request arriving while the CPU access is in flight
        @(negedge clk); setr(0, 0, 1, 0, 16'h0010, 8'h00);
        @(negedge clk); setr(0, 0, 0, 0, 16'h0000, 8'h00); setr(0, 1, 1, 0, 16'h0020, 8'h00); #3;
        chk("busy_hold1", 0, 32'(act[0].ready), 32'h0);
        @(negedge clk); #3;
        chk("busy_hold2", 0, 32'(act[0].ready), 32'h0);
        @(negedge clk); #3;
        chk("busy_hold3", 0, 32'(act[0].ready), 32'h0);
        @(negedge clk); #3;
        chk("busy_accept", 0, 32'(act[0].ready), 32'h2);
        @(negedge clk); setr(0, 1, 0, 0, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);

        // reset during the second enabled cycle of a CPU read
        setr(0, 0, 1, 0, 16'h0030, 8'h00);
        @(negedge clk); setr(0, 0, 0, 0, 16'h0000, 8'h00);
        @(negedge clk); resetn = 1'b0; #3;
        chk("abort_en", 0, 32'(act[0].en), 32'd1);
        @(negedge clk); resetn = 1'b1; #3;
        chk("abort_en0", 0, 32'(act[0].en), 32'd0);
        chk("abort_busy", 0, 32'(act[0].busy), 32'd0);
        chk("abort_rsp", 0, 32'(act[0].rsp), 32'd0);
        chk("abort_addr", 0, 32'(act[0].addr), 32'd0);
        chk("abort_rdata", 0, 32'(act[0].rdata), 32'd0);

        // tie after reset: both continuously valid for four accesses
        @(negedge clk); setr(0, 0, 1, 0, 16'h0040, 8'h00); setr(0, 1, 1, 0, 16'h0041, 8'h00); #3;
        chk("tie_first", 0, 32'(act[0].ready), 32'h1);
        if (act[0].ready != 2'b00) grants.push_back(act[0].ready[1]);
        repeat (15) begin
            @(negedge clk); #3;
            if (act[0].ready != 2'b00) grants.push_back(act[0].ready[1]);
        end
        @(negedge clk); v[0] = 2'b00;
        chk("tie_count", 0, 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("tie_order", 0, 32'(grants[i]), 32'(i % 2));
        repeat (4) @(negedge clk);

        // single-wait instance: back-to-back CPU reads
        setr(1, 0, 1, 0, 16'h0042, 8'h00);
        pulses = 0; en_cnt = 0; first = -1;
        for (int k = 0; k < 9; k++) begin
            #3;
            if (act[1].en) en_cnt++;
            if (act[1].rsp == 2'b01) begin
                pulses++;
                if (first < 0) first = k;
                chk("w1_rdata", 1, 32'(act[1].rdata), 32'h42);
            end
            @(negedge clk);
        end
        v[1] = 2'b00;
        chk("w1_pulses", 1, 32'(pulses), 32'd3);
        chk("w1_en_cycles", 1, 32'(en_cnt), 32'd3);
        chk("w1_first_rsp", 1, 32'(first), 32'd2);
        repeat (3) @(negedge clk);

        // randomized traffic on both instances, requesters obey the hold rule
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            resetn = (k != 200);
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 2; i++)
                    if (!v[j][i] || accd[j][i])
                        setr(j, i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                             16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom));
            #3;
            for (int j = 0; j < 2; j++) accd[j] = resetn ? (v[j] & act[j].ready) : 2'b00;
        end
        @(negedge clk);
        v[0] = 2'b00;
        v[1] = 2'b00;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
